// File: rtl/hls_macc_result_collector.sv
`default_nettype none
// ============================================================================
// Module  : hls_macc_result_collector
// Brief   : Gathers out1..out3 per ap_done frame into a FIFO valid/ready stream.
//           Define MACC_COLLECT_PARITY_EN to add stored per-field parity.
// Revision: 1.0
// ============================================================================
module hls_macc_result_collector #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst,
  input  logic [DATA_W-1:0]      out1,
  input  logic                   out1_ap_vld,
  input  logic [DATA_W-1:0]      out2,
  input  logic                   out2_ap_vld,
  input  logic [DATA_W-1:0]      out3,
  input  logic                   out3_ap_vld,
  input  logic                   ap_done,
  output logic                   can_start,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [3*DATA_W-1:0]    m_data,
  output logic [2:0]             m_mask,
  output logic [$clog2(DEPTH):0] m_count,
  output logic                   err_overflow,
  output logic                   err_dup,
  output logic                   err_timeout,
`ifdef MACC_COLLECT_PARITY_EN
  output logic [2:0]             m_parity,
  output logic                   err_parity,
`endif
  input  logic                   err_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
`ifdef MACC_COLLECT_PARITY_EN
  localparam int PW = 3;
`else
  localparam int PW = 0;
`endif
  localparam int EW = PW + 3 + 3*DATA_W;

  localparam logic [AW:0]   c_depth     = (AW+1)'(DEPTH);
  localparam logic [AW:0]   c_start_lim = (AW+1)'(DEPTH-1);
  localparam logic [CW-1:0] c_cnt_last  = CW'(TIMEOUT-1);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_COLLECT = 1'b1} state_t;

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic [DATA_W-1:0] r_f1, r_f2, r_f3;
  logic [2:0]        r_flags;
  logic [EW-1:0]     r_mem [DEPTH];
  logic [AW:0]       r_wr, r_rd;

  logic [2:0]        w_vld;
  logic [DATA_W-1:0] w_f1, w_f2, w_f3;
  logic [2:0]        w_mask;
  logic              w_dup, w_timeout, w_full, w_pop, w_wr_en, w_ovf;
  logic [EW-1:0]     w_entry, w_head;

  // Same-cycle strobes are merged so ap_done sees the freshest values.
  assign w_vld     = {out3_ap_vld, out2_ap_vld, out1_ap_vld};
  assign w_f1      = out1_ap_vld ? out1 : r_f1;
  assign w_f2      = out2_ap_vld ? out2 : r_f2;
  assign w_f3      = out3_ap_vld ? out3 : r_f3;
  assign w_mask    = r_flags | w_vld;
  assign w_dup     = |(r_flags & w_vld);
  assign w_timeout = (r_state == S_COLLECT) && !ap_done && (r_cnt == c_cnt_last);

`ifdef MACC_COLLECT_PARITY_EN
  assign w_entry = {^w_f3, ^w_f2, ^w_f1, w_mask, w_f3, w_f2, w_f1};
`else
  assign w_entry = {w_mask, w_f3, w_f2, w_f1};
`endif

  assign m_count   = r_wr - r_rd;
  assign m_valid   = (r_wr != r_rd);
  assign w_full    = (m_count == c_depth);
  assign w_pop     = m_valid && m_ready;
  assign w_wr_en   = ap_done && (!w_full || w_pop);
  assign w_ovf     = ap_done && w_full && !w_pop;
  assign w_head    = r_mem[r_rd[AW-1:0]];
  assign m_data    = w_head[3*DATA_W-1:0];
  assign m_mask    = w_head[3*DATA_W +: 3];
  assign can_start = (m_count < c_start_lim) && (r_state == S_IDLE);

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_f1    <= '0;
      r_f2    <= '0;
      r_f3    <= '0;
      r_flags <= '0;
    end else if (ap_done || w_timeout) begin
      r_f1    <= '0;
      r_f2    <= '0;
      r_f3    <= '0;
      r_flags <= '0;
    end else begin
      r_f1    <= w_f1;
      r_f2    <= w_f2;
      r_f3    <= w_f3;
      r_flags <= w_mask;
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!ap_done && (|w_vld)) begin
            r_state <= S_COLLECT;
            r_cnt   <= '0;
          end
        end
        S_COLLECT: begin
          if (ap_done || w_timeout) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Full FIFO with a same-cycle pop overwrites the slot being read out.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_wr <= '0;
      r_rd <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_wr_en) begin
        r_mem[r_wr[AW-1:0]] <= w_entry;
        r_wr                <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      err_overflow <= 1'b0;
      err_dup      <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      err_overflow <= (err_overflow && !err_clr) || w_ovf;
      err_dup      <= (err_dup && !err_clr) || w_dup;
      err_timeout  <= (err_timeout && !err_clr) || w_timeout;
    end
  end

`ifdef MACC_COLLECT_PARITY_EN
  logic [2:0] w_par_calc;
  logic       w_par_bad;

  assign w_par_calc = {^w_head[2*DATA_W +: DATA_W], ^w_head[DATA_W +: DATA_W], ^w_head[0 +: DATA_W]};
  assign m_parity   = w_head[3*DATA_W+3 +: 3];
  assign w_par_bad  = w_pop && (m_parity != w_par_calc);

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) err_parity <= 1'b0;
    else        err_parity <= (err_parity && !err_clr) || w_par_bad;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_hls_macc_result_collector.sv
`default_nettype none
// ============================================================================
// Module  : tb_hls_macc_result_collector
// Brief   : Random and directed frames checked against a queue-based reference.
// Revision: 1.0
// ============================================================================
module tb_hls_macc_result_collector;

  localparam int DATA_W  = 32;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 8;

  logic                   ap_clk = 1'b0;
  logic                   ap_rst = 1'b1;
  logic [DATA_W-1:0]      out1 = '0, out2 = '0, out3 = '0;
  logic                   out1_ap_vld = 1'b0, out2_ap_vld = 1'b0, out3_ap_vld = 1'b0;
  logic                   ap_done = 1'b0;
  logic                   m_ready = 1'b0;
  logic                   err_clr = 1'b0;
  logic                   can_start, m_valid;
  logic [3*DATA_W-1:0]    m_data;
  logic [2:0]             m_mask;
  logic [$clog2(DEPTH):0] m_count;
  logic                   err_overflow, err_dup, err_timeout;

  hls_macc_result_collector #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .out1(out1), .out1_ap_vld(out1_ap_vld),
    .out2(out2), .out2_ap_vld(out2_ap_vld),
    .out3(out3), .out3_ap_vld(out3_ap_vld),
    .ap_done(ap_done), .can_start(can_start),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_mask(m_mask),
    .m_count(m_count), .err_overflow(err_overflow), .err_dup(err_dup),
    .err_timeout(err_timeout), .err_clr(err_clr)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct packed {
    logic [2:0]          mask;
    logic [3*DATA_W-1:0] data;
  } frame_t;

  frame_t sb_q[$];
  frame_t mon_e;
  int     vectors = 0;
  int     miscompares = 0;

  // Reference: pending frame fields, open/closed frame, queued frame count.
  logic [DATA_W-1:0] mv[3];
  bit                mf[3];
  bit                m_open;
  int                m_age;
  int                m_occ;
  bit                me_ovf, me_dup, me_to;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_frame();
    for (int i = 0; i < 3; i++) begin
      mv[i] = '0;
      mf[i] = 1'b0;
    end
    m_open = 1'b0;
    m_age  = 0;
  endtask

  task automatic model_reset();
    clear_frame();
    m_occ  = 0;
    me_ovf = 1'b0;
    me_dup = 1'b0;
    me_to  = 1'b0;
    sb_q.delete();
  endtask

  task automatic model_step(input logic [2:0] v, input logic [DATA_W-1:0] a, b, c,
                            input logic d, r, cl);
    logic [DATA_W-1:0] vals[3];
    bit     pop, dup, ovf, to;
    frame_t f;
    vals[0] = a; vals[1] = b; vals[2] = c;
    pop = r && (m_occ > 0);
    dup = 1'b0; ovf = 1'b0; to = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (v[i]) begin
        if (mf[i]) dup = 1'b1;
        mv[i] = vals[i];
        mf[i] = 1'b1;
      end
    end
    if (d) begin
      for (int i = 0; i < 3; i++) begin
        f.mask[i] = mf[i];
        f.data[i*DATA_W +: DATA_W] = mf[i] ? mv[i] : '0;
      end
      if (m_occ < DEPTH || pop) begin
        sb_q.push_back(f);
        if (!pop) m_occ++;
      end else begin
        ovf = 1'b1;
      end
      clear_frame();
    end else begin
      if (pop) m_occ--;
      if (m_open) begin
        m_age++;
        if (m_age == TIMEOUT) begin
          to = 1'b1;
          clear_frame();
        end
      end else if (v != 3'b000) begin
        m_open = 1'b1;
        m_age  = 0;
      end
    end
    me_ovf = (me_ovf && !cl) || ovf;
    me_dup = (me_dup && !cl) || dup;
    me_to  = (me_to && !cl) || to;
  endtask

  task automatic check_state();
    chk("m_count", m_count, m_occ);
    chk("m_valid", m_valid, m_occ > 0);
    chk("can_start", can_start, (m_occ < DEPTH-1) && !m_open);
    chk("err_overflow", err_overflow, me_ovf);
    chk("err_dup", err_dup, me_dup);
    chk("err_timeout", err_timeout, me_to);
  endtask

  task automatic cycle(input logic [2:0] v, input logic [DATA_W-1:0] a, b, c,
                       input logic d, r, cl);
    out1 = a; out2 = b; out3 = c;
    {out3_ap_vld, out2_ap_vld, out1_ap_vld} = v;
    ap_done = d; m_ready = r; err_clr = cl;
    model_step(v, a, b, c, d, r, cl);
    @(posedge ap_clk);
    #1;
    check_state();
  endtask

  task automatic idle(input int n, input logic r);
    for (int k = 0; k < n; k++) cycle(3'b000, '0, '0, '0, 1'b0, r, 1'b0);
  endtask

  task automatic check_reset_outputs();
    chk("rst_m_count", m_count, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_can_start", can_start, 1);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_mask", m_mask, 0);
    chk("rst_errors", {err_overflow, err_dup, err_timeout}, 0);
  endtask

  // Every accepted head must match the oldest frame the reference queued.
  always @(negedge ap_clk) begin
    if (!ap_rst && m_valid && m_ready) begin
      if (sb_q.size() == 0) begin
        chk("pop_with_empty_scoreboard", m_valid, 0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("m_data", m_data, mon_e.data);
        chk("m_mask", m_mask, mon_e.mask);
      end
    end
  end

  initial begin
    logic [2:0] rv;
    logic       rd, rr, rc;
    model_reset();
    ap_rst = 1'b1;
    repeat (3) @(posedge ap_clk);
    #1;
    check_reset_outputs();
    ap_rst = 1'b0;

    // Fields spread over several cycles, last one with ap_done.
    idle(2, 1'b1);
    cycle(3'b001, 32'h11, '0, '0, 1'b0, 1'b1, 1'b0);
    idle(1, 1'b1);
    cycle(3'b010, '0, 32'h22, '0, 1'b0, 1'b1, 1'b0);
    idle(1, 1'b1);
    cycle(3'b100, '0, '0, 32'h33, 1'b1, 1'b1, 1'b0);
    idle(2, 1'b1);

    // Single field frame.
    cycle(3'b010, '0, 32'hABCD, '0, 1'b0, 1'b1, 1'b0);
    cycle(3'b000, '0, '0, '0, 1'b1, 1'b1, 1'b0);
    idle(2, 1'b1);

    // Duplicate strobe, then clear.
    cycle(3'b001, 32'h5, '0, '0, 1'b0, 1'b1, 1'b0);
    cycle(3'b001, 32'h9, '0, '0, 1'b0, 1'b1, 1'b0);
    cycle(3'b000, '0, '0, '0, 1'b1, 1'b1, 1'b0);
    idle(1, 1'b1);
    cycle(3'b000, '0, '0, '0, 1'b0, 1'b1, 1'b1);

    // Fill with consumer stalled, overflow, then push on full with pop.
    for (int i = 1; i <= 5; i++)
      cycle(3'b111, DATA_W'(i), DATA_W'(i + 16), DATA_W'(i + 32), 1'b1, 1'b0, 1'b0);
    cycle(3'b001, 32'h66, '0, '0, 1'b1, 1'b1, 1'b0);
    idle(6, 1'b1);
    cycle(3'b000, '0, '0, '0, 1'b0, 1'b1, 1'b1);

    // Partial frame abandoned, then an empty frame.
    cycle(3'b001, 32'h77, '0, '0, 1'b0, 1'b1, 1'b0);
    idle(TIMEOUT + 1, 1'b1);
    cycle(3'b000, '0, '0, '0, 1'b1, 1'b1, 1'b0);
    idle(2, 1'b1);

    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) begin
        ap_rst = 1'b1;
        #2;
        model_reset();
        check_reset_outputs();
        @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;
      end
      rv = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
      rd = ($urandom_range(0, 5) == 0);
      rr = ((n / 200) % 2 == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      rc = ($urandom_range(0, 31) == 0);
      cycle(rv, $urandom, $urandom, $urandom, rd, rr, rc);
    end

    idle(DEPTH + 4, 1'b1);
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
